// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiplier controller.
// Early termination is selected by MUL_SEQ_EARLY_TERM_EN in mul_seq_ctrl.
package mul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mul_state_t;

  localparam int MUL_WIDTH = 32;

  // EX-stage request decode keys SMUL off this ALU_Ctrl code.
  localparam logic [3:0] ALU_CTRL_SMUL = 4'd13;

endpackage

// File: rtl/mul_shift_add_step.sv
// One radix-2 shift-add iteration: conditional add of the multiplicand,
// then multiplicand shifts left and multiplier shifts right.
module mul_shift_add_step
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplr_next
);

  logic [2*WIDTH-1:0] addend;

  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand[gi] & mplr[0];
  end

  assign acc_next   = acc + addend;
  assign mcand_next = {mcand[2*WIDTH-2:0], 1'b0};
  assign mplr_next  = {1'b0, mplr[WIDTH-1:1]};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative signed/unsigned multiplier controller with pipeline stall.
// Define MUL_SEQ_EARLY_TERM_EN to stop iterating once the multiplier is exhausted.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t state_reg, state_next;

  logic [WIDTH-1:0]   src1_reg, src2_reg;
  logic               signed_reg;
  logic               neg_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplr_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               accept;
  logic               run_last;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] acc_step, mcand_step;
  logic [WIDTH-1:0]   mplr_step;
  logic [2*WIDTH-1:0] acc_fixed;

  assign accept = start_i & ~flush_i;

  // Negating the most negative value yields its correct unsigned magnitude.
  assign abs1 = (signed_reg && src1_reg[WIDTH-1]) ? -src1_reg : src1_reg;
  assign abs2 = (signed_reg && src2_reg[WIDTH-1]) ? -src2_reg : src2_reg;

  assign acc_fixed = neg_reg ? -acc_reg : acc_reg;

  mul_shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc       (acc_reg),
    .mcand     (mcand_reg),
    .mplr      (mplr_reg),
    .acc_next  (acc_step),
    .mcand_next(mcand_step),
    .mplr_next (mplr_step)
  );

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign run_last = (cnt_reg == CNT_LAST) || (mplr_step == '0);
`else
  assign run_last = (cnt_reg == CNT_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_o  = 1'b0;
        stall_o = accept;
        if (accept) begin
          state_next = PREP;
        end
      end
      PREP: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else begin
`ifdef MUL_SEQ_EARLY_TERM_EN
          state_next = (abs2 == '0) ? FIX : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else if (run_last) begin
          state_next = FIX;
        end
      end
      FIX: begin
        stall_o    = 1'b1;
        state_next = flush_i ? IDLE : DONE;
      end
      DONE: begin
        // Stall drops here so EX captures hi/lo in this cycle.
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src1_reg   <= '0;
      src2_reg   <= '0;
      signed_reg <= 1'b0;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplr_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            src1_reg   <= src1_i;
            src2_reg   <= src2_i;
            signed_reg <= signed_i;
          end
        end
        PREP: begin
          mcand_reg <= {{WIDTH{1'b0}}, abs1};
          mplr_reg  <= abs2;
          neg_reg   <= signed_reg & (src1_reg[WIDTH-1] ^ src2_reg[WIDTH-1]);
          acc_reg   <= '0;
          cnt_reg   <= '0;
        end
        RUN: begin
          acc_reg   <= acc_step;
          mcand_reg <= mcand_step;
          mplr_reg  <= mplr_step;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        FIX: begin
          if (!flush_i) begin
            hi_reg <= acc_fixed[2*WIDTH-1:WIDTH];
            lo_reg <= acc_fixed[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: per-cycle model comparison plus literal pins.
// Honours MUL_SEQ_EARLY_TERM_EN when computing expected latency.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: an accepted operation at cycle m_t0 finishes at m_t0 + m_lat.
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  int          m_lat = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_out = '0;

  mul_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .signed_i(signed_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int model_lat(input bit s, input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [31:0] m;
    int hb;
    m = (s && b[31]) ? -b : b;
    hb = -1;
    for (int i = 0; i < 32; i++) if (m[i]) hb = i;
    return 3 + hb + 1;
`else
    return WIDTH + 3;
`endif
  endfunction

  // Compare outputs for the current cycle, then advance the model past the coming edge.
  task automatic model_compare();
    int rel;
    logic e_busy, e_done, e_stall;
    cyc++;
    rel = cyc - m_t0;
    if (!m_active) begin
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_stall = start_i & ~flush_i;
    end else begin
      e_busy  = 1'b1;
      e_done  = (rel == m_lat);
      e_stall = (rel < m_lat);
    end
    check("busy", 64'(busy_o), 64'(e_busy));
    check("done", 64'(done_o), 64'(e_done));
    check("stall", 64'(stall_o), 64'(e_stall));
    check("hi_lo", {hi_o, lo_o}, m_out);
    if (rst_i) begin
      m_active = 1'b0;
      m_out    = '0;
    end else if (m_active) begin
      if (flush_i || rel == m_lat) m_active = 1'b0;
      else if (rel == m_lat - 1) m_out = m_prod;
    end else if (start_i && !flush_i) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_prod   = model_prod(signed_i, src1_i, src2_i);
      m_lat    = model_lat(signed_i, src2_i);
    end
  endtask

  task automatic cycle_step();
    @(negedge clk_i);
    model_compare();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issue one multiply; optionally poke start_i and scramble operands while it runs.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit poke,
                        output logic [63:0] res, output int lat, output int stalls);
    bit seen;
    seen     = 1'b0;
    res      = '0;
    lat      = 0;
    start_i  = 1'b1;
    signed_i = s;
    src1_i   = a;
    src2_i   = b;
    #1;
    stalls = stall_o ? 1 : 0;
    cycle_step();
    for (int i = 1; i <= 100; i++) begin
      start_i  = poke && ($urandom_range(0, 5) == 0);
      signed_i = 1'($urandom_range(0, 1));
      src1_i   = $urandom;
      src2_i   = $urandom;
      #1;
      if (stall_o) stalls++;
      if (done_o) begin
        seen = 1'b1;
        lat  = i;
        res  = {hi_o, lo_o};
      end
      cycle_step();
      if (seen) break;
    end
    start_i = 1'b0;
    check("done_seen", 64'(seen), 64'(1));
    $display("op signed=%0d %h x %h -> %h latency %0d stall %0d", s, a, b, res, lat, stalls);
  endtask

  task automatic pinned(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res);
    logic [63:0] res;
    int lat, stalls;
    run_op(s, a, b, 1'b0, res, lat, stalls);
    check({name, "_product"}, res, exp_res);
    check({name, "_latency"}, 64'(lat), 64'(model_lat(s, b)));
    check({name, "_stall_cycles"}, 64'(stalls), 64'(lat));
  endtask

  initial begin
    logic [63:0] res;
    int lat, stalls, dones;
    logic [63:0] prev;

    repeat (3) cycle_step();
    rst_i = 1'b0;
    #1;
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_out", {hi_o, lo_o}, 64'(0));
    cycle_step();

    pinned("smul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
`ifndef MUL_SEQ_EARLY_TERM_EN
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, res, lat, stalls);
    check("smul_7_m3_lat35", 64'(lat), 64'(35));
    check("smul_7_m3_stall35", 64'(stalls), 64'(35));
`endif
    pinned("umul_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    pinned("smul_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    pinned("mul_by_zero", 1'b0, 32'd1234, 32'd0, 64'h0);
    pinned("mul_5_by_1", 1'b0, 32'd5, 32'd1, 64'h5);
    pinned("umul_msb", 1'b0, 32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000);
`ifdef MUL_SEQ_EARLY_TERM_EN
    run_op(1'b0, 32'd9, 32'd0, 1'b0, res, lat, stalls);
    check("early_zero_lat3", 64'(lat), 64'(3));
    run_op(1'b0, 32'd5, 32'd1, 1'b0, res, lat, stalls);
    check("early_one_lat4", 64'(lat), 64'(4));
    run_op(1'b0, 32'd3, 32'h8000_0000, 1'b0, res, lat, stalls);
    check("early_msb_lat35", 64'(lat), 64'(35));
`endif

    // Flush in the middle of RUN: no completion, previous result retained.
    prev     = {hi_o, lo_o};
    start_i  = 1'b1;
    signed_i = 1'b0;
    src1_i   = 32'd77;
    src2_i   = 32'd99;
    cycle_step();
    start_i = 1'b0;
    repeat (9) cycle_step();
    flush_i = 1'b1;
    cycle_step();
    flush_i = 1'b0;
    #1;
    check("flush_idle", 64'(busy_o), 64'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) dones++;
      cycle_step();
    end
    check("flush_no_done", 64'(dones), 64'(0));
    check("flush_keeps_out", {hi_o, lo_o}, prev);
    $display("op flush at T+10 done_count %0d out %h", dones, {hi_o, lo_o});

    // Start together with flush in IDLE is not accepted.
    start_i = 1'b1;
    flush_i = 1'b1;
    cycle_step();
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("start_flush_rejected", 64'(busy_o), 64'(0));
    cycle_step();
    $display("op start+flush in IDLE busy %0d", busy_o);

    // Reset in the middle of an operation.
    start_i  = 1'b1;
    signed_i = 1'b1;
    src1_i   = 32'hFFFF_FF00;
    src2_i   = 32'd1000;
    cycle_step();
    start_i = 1'b0;
    repeat (19) cycle_step();
    rst_i = 1'b1;
    cycle_step();
    rst_i = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy_o), 64'(0));
    check("rst_mid_out", {hi_o, lo_o}, 64'(0));
    check("rst_mid_done", 64'(done_o), 64'(0));
    $display("op reset at T+20 busy %0d out %h", busy_o, {hi_o, lo_o});
    cycle_step();

    // Randomized operations with ignored start pulses while busy.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit s;
      a = pick();
      b = pick();
      s = 1'($urandom_range(0, 1));
      run_op(s, a, b, 1'b1, res, lat, stalls);
      check("rand_product", res, model_prod(s, a, b));
      repeat ($urandom_range(0, 3)) cycle_step();
    end

    repeat (3) cycle_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
